fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and PC sequencer for the pipelined MIPS core. It owns the PC, issues one-outstanding-request reads to instruction memory, and holds the IF/ID pipeline register whose `id_instr` drives the decoder's Op/Rt/Funct fields. It consumes the decoder's `PCSrc` result to redirect fetch for branches, J and JR, and squashes wrong-path sequential fetches. There is no branch delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `imem_req`  out  1  read request; held until `imem_ack`.
- `imem_addr`  out  32  word address of request, equals internal `pc`; bits [1:0] always 0.
- `imem_ack`  in  1  read completion, sampled only while `imem_req`=1; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds a live instruction.
- `id_instr`  out  32  IF/ID instruction, feeding decoder Op=[31:26], Rt=[20:16], Funct=[5:0].
- `id_pc4`  out  32  address of `id_instr` + 4.
- `id_stall`  in  1  hazard unit holds ID; IF/ID must not change while `id_valid`=1.
- `PCSrc`  in  2  from decoder: 0 = +4, 1 = branch taken, 2 = J, 3 = JR.
- `jr_target`  in  32  forwarded Reg[rs] for JR.

## Operation
- `adv` = `id_valid` & ~`id_stall`, meaning the ID instruction leaves ID this cycle. `redir` = `adv` & (`PCSrc`≠0). `PCSrc` is ignored when `adv`=0.
- Targets:
  - Branch: `id_pc4` + {{14{id_instr[15]}}, id_instr[15:0], 2'b00}.
  - J: {id_pc4[31:28], id_instr[25:0], 2'b00}.
  - JR: {jr_target[31:2], 2'b00}.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- One-entry skid buffer (`skid_instr`, `skid_pc4`) and `pend_pc` register.
- States:
  - BOOT: `imem_req`=0. Next state is REQ.
  - REQ: `imem_req`=1, `imem_addr`=`pc` stable.
    - `redir` & ack: discard data, `pc`←target, `id_valid`←0, stay in REQ.
    - `redir` & ~ack: `pend_pc`←target, `id_valid`←0, go to SQUASH.
    - ~`redir` & ack & (~`id_valid` | ~`id_stall`): IF/ID←{rdata, pc+4}, `id_valid`←1, `pc`←pc+4.
    - ~`redir` & ack & `id_valid` & `id_stall`: skid←{rdata, pc+4}, `pc`←pc+4, go to HOLD.
    - ~`redir` & ~ack & `adv`: `id_valid`←0.
  - HOLD: `imem_req`=0.
    - `redir`: discard skid, `pc`←target, `id_valid`←0, go to REQ.
    - else if ~`id_stall`: IF/ID←skid, `id_valid`←1, go to REQ.
  - SQUASH: `imem_req`=1 at the old `pc`. On ack, discard data, `pc`←`pend_pc`, go to REQ. `id_valid` stays 0, so no redirect can occur.
- Reset (asynchronous, `rst`=0): state=BOOT, `pc`=RESET_PC, `imem_req`=0, `id_valid`=0, `id_instr`=0, `id_pc4`=0, skid=0, `pend_pc`=0. Reset mid-request abandons the request; a late ack is ignored because `imem_req`=0.

## Timing
- First `imem_req` rises 1 cycle after `rst` deasserts (BOOT lasts 1 cycle).
- A zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle; `id_instr` is updated on the ack edge.
- Redirect penalty:
  - With ack in the same cycle: 1 bubble. The target is requested the next cycle.
  - Without ack: wait for ack, then 1 cycle to request the target.
- `imem_addr` and `imem_req` are registered-state outputs with no combinational path from `imem_ack`.
- Outputs are stable while `id_stall`=1 and `id_valid`=1.

## Test plan
- Reset + zero-wait sequential: RESET_PC=0, ack every cycle → `imem_addr` 0,4,8,…; `id_pc4` 4,8,12 on consecutive cycles after BOOT.
- Taken BEQ: `id_instr` imm=16'hFFFE, `id_pc4`=0x20, `PCSrc`=1, ack same cycle → next `imem_addr`=0x18; the fetch from 0x20 is discarded; `id_valid`=0 for one cycle.
- J/JR: J with instr[25:0]=26'h40, `id_pc4`=0x8000_0010 → target 0x8000_0100. JR with `jr_target`=0x1237 → target 0x1234.
- Stall with skid: `id_stall`=1 while ack arrives → HOLD, `imem_req`=0, IF/ID unchanged. Release → skid word appears in IF/ID and `imem_req` reasserts at the next address.
- Redirect during slow memory: ack delayed 3 cycles, `PCSrc`=2 while waiting → SQUASH, old address held until ack, data dropped, then request at the J target.
- Async reset mid-request: drop `rst` while in REQ/HOLD → `imem_req`, `id_valid`=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: one outstanding request, held until ack.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage / PC sequencer: owns the PC, issues one-outstanding imem reads,
// holds the IF/ID register and redirects on branch/J/JR (no delay slot).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,        // async, active low
  fetch_unit_if.master       imem,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc4,
  input  logic               id_stall,
  input  logic [1:0]         PCSrc,
  input  logic [31:0]        jr_target
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_SQUASH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        adv, redir, ack;
  logic [31:0] pc4, target;

  // Low address bits of the JR source are forced to zero and never used.
  logic unused_jr;
  assign unused_jr = ^jr_target[1:0];

  assign adv   = id_valid_q & ~id_stall;
  assign redir = adv & (PCSrc != 2'd0);
  // ack only means something while a request is actually out.
  assign ack   = imem.ack & req_q;
  assign pc4   = pc_q + 32'd4;

  // Redirect target chosen by the decoder's PCSrc for the instruction in ID.
  always_comb begin
    target = id_pc4_q;
    case (PCSrc)
      2'd1:    target = id_pc4_q + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
      2'd2:    target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
      2'd3:    target = {jr_target[31:2], 2'b00};
      default: target = id_pc4_q;
    endcase
  end

  // Next-state logic for the sequencer, IF/ID register, skid and pending PC.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    pend_pc_d    = pend_pc_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (redir) begin
          id_valid_d = 1'b0;
          if (ack) pc_d = target;          // wrong-path data dropped
          else begin
            pend_pc_d = target;            // must still drain the old request
            state_d   = S_SQUASH;
          end
        end else if (ack) begin
          pc_d = pc4;
          if (!id_valid_q || !id_stall) begin
            id_instr_d = imem.rdata;
            id_pc4_d   = pc4;
            id_valid_d = 1'b1;
          end else begin
            skid_instr_d = imem.rdata;
            skid_pc4_d   = pc4;
            state_d      = S_HOLD;
          end
        end else if (adv) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (!id_stall) begin
          id_instr_d = skid_instr_q;
          id_pc4_d   = skid_pc4_q;
          id_valid_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_SQUASH: begin
        if (ack) begin
          pc_d    = pend_pc_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Request is a registered function of the next state: no ack-to-req path.
  assign req_d = (state_d == S_REQ) || (state_d == S_SQUASH);

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc4_q     <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      pend_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;

endmodule
